// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-port register file
//
// Purpose: default widths, the clear/ready state type and the read-port
// slice helper used by regfile_mp and regfile_scoreboard.
// Ports: none (package).
// Build option: REGFILE_BYPASS_EN (consumed by regfile_mp / regfile_scoreboard).

package regfile_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // LSB of port `port` inside a flattened bus whose per-port field is `width` bits.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-producer flags with per-port lookup
//
// Purpose: one busy flop per architectural register. Alloc sets a flag, a
// write clears it; alloc wins when both target the same register in a cycle.
// Register 0 is never busy.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_en                   file is READY; alloc/write ignored otherwise, lookups read 0
//   i_w_en, i_w_addr       writeback (clears the flag)
//   i_alloc_en, i_alloc_addr  decode issue (sets the flag)
//   i_rd_addr              flattened read addresses, port k at [k*AW +: AW]
//   o_rd_busy              per-port busy view
// Build option: REGFILE_BYPASS_EN makes a same-cycle write visible on o_rd_busy.

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_w_en,
  input  logic [AW-1:0]     i_w_addr,
  input  logic              i_alloc_en,
  input  logic [AW-1:0]     i_alloc_addr,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  output logic [NUM_RD-1:0] o_rd_busy
);

  logic [NUM_REGS-1:0] busy;

  // Clear first, then set: a same-cycle alloc to the written register wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy <= '0;
    end else if (i_en) begin
      if (i_w_en && (i_w_addr != '0)) begin
        busy[i_w_addr] <= 1'b0;
      end
      if (i_alloc_en && (i_alloc_addr != '0)) begin
        busy[i_alloc_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [AW-1:0] addr;
    logic          busy_k;

    assign addr = i_rd_addr[port_lsb(k, AW) +: AW];

    always_comb begin
      busy_k = i_en && (addr != '0) && busy[addr];
`ifdef REGFILE_BYPASS_EN
      // The write retiring this cycle already resolves the hazard, unless a
      // new producer is being allocated to the same register right now.
      if (i_en && i_w_en && (i_w_addr != '0) && (addr == i_w_addr)) begin
        busy_k = i_alloc_en && (i_alloc_addr == addr);
      end
`endif
    end

    assign o_rd_busy[k] = busy_k;
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port integer register file with post-reset clear
//
// Purpose: NUM_REGS x XLEN register file, one synchronous write port,
// NUM_RD combinational read ports, hardwired x0, a sequential clear engine
// after reset and a pending-producer scoreboard for RAW detection.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_rd_addr         read addresses, port k at [k*AW +: AW]
//   o_rd_data         read data, port k at [k*XLEN +: XLEN]
//   o_rd_busy         port k's register has a pending producer
//   i_w_en, i_w_addr, i_w_val    writeback port
//   i_alloc_en, i_alloc_addr     mark register pending
//   o_ready           clear finished, traffic accepted
// Build option: REGFILE_BYPASS_EN forwards a same-cycle write to matching read ports.

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_RD*AW-1:0]   i_rd_addr,
  output logic [NUM_RD*XLEN-1:0] o_rd_data,
  output logic [NUM_RD-1:0]      o_rd_busy,
  input  logic                   i_w_en,
  input  logic [AW-1:0]          i_w_addr,
  input  logic [XLEN-1:0]        i_w_val,
  input  logic                   i_alloc_en,
  input  logic [AW-1:0]          i_alloc_addr,
  output logic                   o_ready
);

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic          ready;

  logic [XLEN-1:0] mem [NUM_REGS];

  // Clear engine: entry 0 is never stored (reads of x0 are forced to zero),
  // so the sweep starts at 1 and finishes after NUM_REGS-1 cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= CLEAR;
      clr_cnt <= AW'(1);
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(NUM_REGS - 1)) begin
            state <= READY;
          end
        end
        READY: state <= READY;
        default: state <= CLEAR;
      endcase
    end
  end

  assign ready   = (state == READY);
  assign o_ready = ready;

  // Storage has no reset; the clear engine owns the write port until READY.
  always_ff @(posedge i_clk) begin
    if (!ready) begin
      mem[clr_cnt] <= '0;
    end else if (i_w_en && (i_w_addr != '0)) begin
      mem[i_w_addr] <= i_w_val;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data_k;

    assign addr = i_rd_addr[port_lsb(k, AW) +: AW];

    always_comb begin
      data_k = '0;
      if (ready && (addr != '0)) begin
        data_k = mem[addr];
`ifdef REGFILE_BYPASS_EN
        if (i_w_en && (addr == i_w_addr)) begin
          data_k = i_w_val;
        end
`endif
      end
    end

    assign o_rd_data[port_lsb(k, XLEN) +: XLEN] = data_k;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .AW       (AW)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (ready),
    .i_w_en       (i_w_en),
    .i_w_addr     (i_w_addr),
    .i_alloc_en   (i_alloc_en),
    .i_alloc_addr (i_alloc_addr),
    .i_rd_addr    (i_rd_addr),
    .o_rd_busy    (o_rd_busy)
  );

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised integer register file for the RISC-V core; next generation of the current 2-read/1-write file.
- Sits between decode (operand read) and writeback (result write).
- Adds: clocked synchronous write, configurable read-port count, hardwired x0, and a sequential post-reset clear engine with a ready flag.
- Adds a per-register pending scoreboard so decode can detect RAW hazards.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of read ports; 1 to 4.
- AW, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_rd_addr  input  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- o_rd_data  output  NUM_RD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- o_rd_busy  output  NUM_RD  port k's register has a pending producer.
- i_w_en  input  1  write enable.
- i_w_addr  input  AW  write address.
- i_w_val  input  XLEN  write data.
- i_alloc_en  input  1  mark a register as pending (decode issued a producer).
- i_alloc_addr  input  AW  register to mark pending.
- o_ready  output  1  clear complete; the file accepts traffic.

Behaviour:
- Reset: i_rst asynchronously forces state CLEAR, clear counter = 1, all busy bits = 0, o_ready = 0.
  - While reset or CLEAR is active: o_rd_data = 0 for every port; o_rd_busy = 0.
  - Array contents are not reset asynchronously.
- State CLEAR:
  - Each cycle writes 0 to entry[counter], then counter increments.
  - After entry NUM_REGS-1 is written, next state is READY.
  - The clear takes NUM_REGS-1 cycles after reset deassertion.
  - o_ready rises in the first cycle after the last clear write.
  - i_w_en and i_alloc_en are ignored in CLEAR.
  - Reset asserted mid-clear restarts at counter = 1.
- State READY:
  - Only leaves READY on i_rst.
  - Reads are combinational: o_rd_data[k] = entry[i_rd_addr[k]].
  - Address 0 always reads 0 and is never busy.
- Write:
  - When i_w_en = 1 and i_w_addr != 0, entry[i_w_addr] <= i_w_val at the rising edge.
  - That register's busy bit is cleared at the same edge.
  - Writes to address 0 are dropped.
- Alloc:
  - When i_alloc_en = 1 and i_alloc_addr != 0, busy[i_alloc_addr] <= 1.
  - Alloc to address 0 is ignored.
- Alloc and write to the same register in the same cycle: data is written and busy ends set (the new producer wins).
- Alloc and write to different registers: both take effect.
- Read ports are independent; any number of ports may share an address.
- o_rd_busy[k] = busy[i_rd_addr[k]], registered-bit view, combinational decode.
- Addresses are always in range (2^AW = NUM_REGS); no wrap handling needed.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle bypass.
  - If i_w_en = 1, i_w_addr != 0, state is READY and i_rd_addr[k] == i_w_addr, then o_rd_data[k] = i_w_val and o_rd_busy[k] = 0 in that cycle.
  - An alloc to the same address in the same cycle still forces o_rd_busy[k] = 1.
- Undefined: the written value and the cleared busy bit become visible the cycle after the write edge. Reads in the write cycle return the old value and old busy.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN and NUM_REGS constants;
  - the state typedef (enum CLEAR, READY; 1 bit);
  - a function for read-port slice extraction.
- One natural sub-module: regfile_scoreboard, holding the NUM_REGS busy flops plus alloc/clear logic and per-port lookup.
- Storage array, clear FSM and read muxes stay in regfile_mp.

Test Plan:
- Reset clear: assert i_rst 2 cycles, release → o_ready = 0 for exactly 31 cycles, then 1; all 32 addresses read 0.
- Write then read: write x5 = 0xDEADBEEF, next cycle read port 0 addr 5 → 0xDEADBEEF; port 1 addr 0 → 0.
- x0 guard: write x0 = 0xFFFFFFFF, alloc x0 → x0 reads 0, o_rd_busy for addr 0 = 0.
- Scoreboard:
  - alloc x7 → next cycle busy(x7) = 1;
  - write x7 = 0x12 → next cycle busy = 0, data 0x12;
  - same-cycle alloc+write x7 = 0x34 → data 0x34, busy = 1.
- Bypass: write x9 = 0xA5A5A5A5 while port 1 reads x9.
  - With REGFILE_BYPASS_EN: same cycle 0xA5A5A5A5, busy 0.
  - Without: old value that cycle, new value next cycle.
- Reset mid-clear: reassert i_rst at clear cycle 10 → counter restarts; o_ready rises 31 cycles after the second release; a write issued during CLEAR is not retained (reads 0 afterwards).
